// File: rtl/rect_fill_engine.sv
// Sweeps a clamped rectangle, or the whole screen, in raster order and writes one fill-colour pixel per accepted cycle.
// Latency: the first pixel is valid the cycle after start is accepted; done pulses the cycle after the last transfer.
// Backpressure: x/y/color hold while pix_ready is low; we stays high for the whole sweep.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, mode         job request (sampled in IDLE only); mode 1 = full-screen clear, 0 = rectangle
//   x0, y0, x1, y1      inclusive rectangle corners (mode 0 only)
//   fill_color          colour for every pixel of the job
//   pix_ready           framebuffer accepts the current pixel
//   we, x, y, color     pixel write strobe and payload
//   busy, done          job in progress / one-cycle completion pulse
module rect_fill_engine #(
  parameter int COORD_W  = 11,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int COLOR_W  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               mode,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic [COLOR_W-1:0] fill_color,
  input  logic               pix_ready,
  output logic               we,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               done
);

  generate
    if ((2 ** COORD_W) <= ((SCREEN_W > SCREEN_H) ? SCREEN_W : SCREEN_H)) begin : g_coord_w_check
      $error("rect_fill_engine: COORD_W too narrow for the screen size");
    end
  endgenerate

  localparam logic [COORD_W-1:0] SCR_W  = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] SCR_H  = COORD_W'(SCREEN_H);
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t state, state_nxt;

  // Effective region computed straight from the request inputs; only used in IDLE.
  logic [COORD_W-1:0] xs_c, ys_c, xe_c, ye_c;
  logic               empty_c;

  // Latched region and the sweep position.
  logic [COORD_W-1:0] xs_q, ys_q, xe_q, ye_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [COLOR_W-1:0] color_q;
  logic               last_pix;

  always_comb begin
    xs_c    = '0;
    ys_c    = '0;
    xe_c    = X_LAST;
    ye_c    = Y_LAST;
    empty_c = 1'b0;
    if (!mode) begin
      xs_c    = x0;
      ys_c    = y0;
      xe_c    = (x1 > X_LAST) ? X_LAST : x1;
      ye_c    = (y1 > Y_LAST) ? Y_LAST : y1;
      // An off-screen start corner is empty even before the clamp makes xs>xe obvious.
      empty_c = (x0 >= SCR_W) || (y0 >= SCR_H) || (x0 > xe_c) || (y0 > ye_c);
    end
  end

  assign last_pix = (x_q == xe_q) && (y_q == ye_q);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = empty_c ? FIN : RUN;
      RUN:  if (pix_ready && last_pix) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Region latch and raster stepping. A reset mid-job simply drops the sweep.
  always_ff @(posedge clk) begin
    if (reset) begin
      xs_q    <= '0;
      ys_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else if (state == IDLE && start) begin
      xs_q    <= xs_c;
      ys_q    <= ys_c;
      xe_q    <= xe_c;
      ye_q    <= ye_c;
      x_q     <= xs_c;
      y_q     <= ys_c;
      color_q <= fill_color;
    end else if (state == RUN && pix_ready && !last_pix) begin
      if (x_q == xe_q) begin
        x_q <= xs_q;
        y_q <= y_q + COORD_W'(1);
      end else begin
        x_q <= x_q + COORD_W'(1);
      end
    end
  end

  // Outputs; the last coordinate stays visible through FIN and IDLE.
  always_comb begin
    we    = (state == RUN);
    busy  = (state == RUN);
    done  = (state == FIN);
    x     = x_q;
    y     = y_q;
    color = color_q;
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
module tb_rect_fill_engine;

  logic        clk = 1'b0;
  logic        reset, start, mode, pix_ready, fill_color, sel;
  logic [10:0] x0, y0, x1, y1;

  // dut_a: 640x480 screen, dut_b: 8x4 screen (keeps full-screen clears short).
  logic        start_a, start_b;
  logic        we_a, busy_a, done_a, color_a;
  logic        we_b, busy_b, done_b, color_b;
  logic [10:0] x_a, y_a, x_b, y_b;
  logic        we_m, busy_m, done_m, color_m;
  logic [10:0] x_m, y_m;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign we_m    = sel ? we_b    : we_a;
  assign busy_m  = sel ? busy_b  : busy_a;
  assign done_m  = sel ? done_b  : done_a;
  assign color_m = sel ? color_b : color_a;
  assign x_m     = sel ? x_b     : x_a;
  assign y_m     = sel ? y_b     : y_a;

  rect_fill_engine dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .fill_color(fill_color),
    .pix_ready(pix_ready), .we(we_a), .x(x_a), .y(y_a), .color(color_a),
    .busy(busy_a), .done(done_a)
  );

  rect_fill_engine #(.SCREEN_W(8), .SCREEN_H(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .fill_color(fill_color),
    .pix_ready(pix_ready), .we(we_b), .x(x_b), .y(y_b), .color(color_b),
    .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit m;
    int x0, y0, x1, y1;
    bit col;
    int rmode;    // 0 ready high, 1 toggle 1,0,1,0.., 2 random
    bit s;        // 1 selects the 8x4 instance
    int exp_we;   // expected we-high cycles (ignored for random ready)
    bit perturb;  // hammer start/coords/colour while the job runs
  } vec_t;

  // Runs one job and checks it against the list of pixels the rules say it must write.
  task automatic run_job(input vec_t v);
    int W, H, xs, ys, xe, ye, lx, ly;
    int qx[$];
    int qy[$];
    int we_cnt, busy_cnt, last_xfer, done_cyc, budget, cyc;
    bit fin;
    W = v.s ? 8 : 640;
    H = v.s ? 4 : 480;
    if (v.m) begin
      xs = 0; ys = 0; xe = W - 1; ye = H - 1;
    end else begin
      xs = v.x0; ys = v.y0;
      xe = (v.x1 < W - 1) ? v.x1 : W - 1;
      ye = (v.y1 < H - 1) ? v.y1 : H - 1;
    end
    for (int yy = ys; yy <= ye; yy++)
      for (int xx = xs; xx <= xe; xx++) begin
        qx.push_back(xx);
        qy.push_back(yy);
      end
    lx = xs; ly = ys;
    we_cnt = 0; busy_cnt = 0; last_xfer = -1; done_cyc = -1; fin = 0;
    budget = 4 * qx.size() + 20;

    sel = v.s; mode = v.m; fill_color = v.col;
    x0 = 11'(v.x0); y0 = 11'(v.y0); x1 = 11'(v.x1); y1 = 11'(v.y1);
    start = 1'b1; pix_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    for (cyc = 0; cyc < budget && !fin; cyc++) begin
      case (v.rmode)
        1:       pix_ready = (cyc % 2 == 0);
        2:       pix_ready = 1'($urandom_range(0, 1));
        default: pix_ready = 1'b1;
      endcase
      if (v.perturb && cyc >= 2) begin
        start = 1'b1; x0 = 11'd0; y0 = 11'd0; x1 = 11'd1; y1 = 11'd1;
        fill_color = ~v.col; mode = ~v.m;
      end
      @(negedge clk);
      if (we_m) begin
        we_cnt++;
        if (qx.size() == 0) begin
          vecs++; errs++;
          $display("FAIL extra_write: write at (%0d,%0d) after all pixels done", x_m, y_m);
        end else begin
          chk("px_x", int'(x_m), qx[0]);
          chk("px_y", int'(y_m), qy[0]);
          chk("px_color", int'(color_m), int'(v.col));
          if (pix_ready) begin
            lx = qx.pop_front();
            ly = qy.pop_front();
            if (qx.size() == 0) last_xfer = cyc;
          end
        end
      end
      if (busy_m) busy_cnt++;
      if (done_m) begin
        fin = 1;
        done_cyc = cyc;
        chk("done_x_hold", int'(x_m), lx);
        chk("done_y_hold", int'(y_m), ly);
        chk("done_busy", int'(busy_m), 0);
      end
      @(posedge clk); #1;
    end
    chk("job_finished", int'(fin), 1);
    chk("pixels_left", qx.size(), 0);
    chk("done_cycle", done_cyc, last_xfer + 1);
    chk("busy_cycles", busy_cnt, we_cnt);
    if (v.rmode != 2) chk("we_cycles", we_cnt, v.exp_we);

    // The IDLE cycle after done: a start held through FIN must not have launched a job.
    start = 1'b0;
    @(negedge clk);
    chk("idle_we", int'(we_m), 0);
    chk("idle_busy", int'(busy_m), 0);
    chk("idle_done", int'(done_m), 0);
    @(posedge clk); #1;
  endtask

  vec_t tbl[11];
  vec_t rv;

  initial begin
    tbl[0]  = '{1'b1, 0, 0, 0, 0, 1'b1, 0, 1'b1, 32, 1'b0};         // full clear 8x4
    tbl[1]  = '{1'b0, 2, 1, 4, 2, 1'b1, 0, 1'b0, 6, 1'b0};          // 3x2 rect
    tbl[2]  = '{1'b0, 2, 1, 4, 2, 1'b1, 1, 1'b0, 11, 1'b0};         // same, toggling ready
    tbl[3]  = '{1'b0, 630, 470, 700, 500, 1'b1, 0, 1'b0, 100, 1'b0}; // clamped corner
    tbl[4]  = '{1'b0, 5, 0, 3, 2, 1'b1, 0, 1'b0, 0, 1'b0};          // x0 > x1
    tbl[5]  = '{1'b0, 640, 0, 650, 2, 1'b0, 0, 1'b0, 0, 1'b0};      // x0 off screen
    tbl[6]  = '{1'b0, 3, 480, 5, 490, 1'b1, 0, 1'b0, 0, 1'b0};      // y0 off screen
    tbl[7]  = '{1'b0, 639, 479, 639, 479, 1'b1, 0, 1'b0, 1, 1'b0};  // single pixel
    tbl[8]  = '{1'b0, 6, 2, 20, 20, 1'b0, 0, 1'b1, 4, 1'b0};        // clamp on 8x4
    tbl[9]  = '{1'b1, 3, 3, 1, 1, 1'b1, 1, 1'b1, 63, 1'b0};         // clear, toggling ready
    tbl[10] = '{1'b0, 2, 1, 4, 2, 1'b1, 0, 1'b0, 6, 1'b1};          // start/coords changed mid-job

    reset = 1'b1; start = 1'b0; mode = 1'b0; pix_ready = 1'b0; fill_color = 1'b0;
    sel = 1'b0; x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      @(negedge clk);
      chk("rst_we", int'(we_m), 0);
      chk("rst_busy", int'(busy_m), 0);
      chk("rst_done", int'(done_m), 0);
      chk("rst_x", int'(x_m), 0);
      chk("rst_y", int'(y_m), 0);
      chk("rst_color", int'(color_m), 0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_job(tbl[i]);

    // Reset on the 3rd pixel of a 6-pixel job: abandoned with no done, then a clean rerun.
    sel = 1'b0; mode = 1'b0; fill_color = 1'b1; pix_ready = 1'b1;
    x0 = 11'd2; y0 = 11'd1; x1 = 11'd4; y1 = 11'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_we", int'(we_m), 1);
    chk("pre_reset_x", int'(x_m), 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_we", int'(we_m), 0);
    chk("post_reset_busy", int'(busy_m), 0);
    chk("post_reset_x", int'(x_m), 0);
    chk("post_reset_y", int'(y_m), 0);
    chk("post_reset_done", int'(done_m), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abandoned_no_done", int'(done_m), 0);
    end
    @(posedge clk); #1;
    run_job(tbl[1]);

    // Random jobs against the pixel-list model.
    for (int i = 0; i < 24; i++) begin
      rv.s = 1'($urandom_range(0, 1));
      rv.m = rv.s ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rv.s) begin
        rv.x0 = $urandom_range(0, 9);
        rv.y0 = $urandom_range(0, 5);
      end else begin
        rv.x0 = $urandom_range(600, 645);
        rv.y0 = $urandom_range(0, 484);
      end
      rv.x1 = rv.x0 + $urandom_range(0, 8) - 1;
      rv.y1 = rv.y0 + $urandom_range(0, 4) - 1;
      if (rv.x1 < 0) rv.x1 = 0;
      if (rv.y1 < 0) rv.y1 = 0;
      rv.col = 1'($urandom_range(0, 1));
      rv.rmode = 2;
      rv.exp_we = 0;
      rv.perturb = 1'($urandom_range(0, 1));
      run_job(rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
